date_sequencer: RTL and testbench
=================================

DATE_SEQUENCER -- requirements
Module: date_sequencer

Interface
REQ-001: The block SHALL have parameter SYNC_STAGES, default 2, the number of button synchronizer flops.
REQ-002: The block SHALL have parameter HOLD_CYCLES, default 25_000_000, the held-button cycles before auto-repeat starts.
REQ-003: The block SHALL have parameter REPEAT_CYCLES, default 5_000_000, the cycles between auto-repeat steps.
REQ-004: Ports SHALL be:
  clk  input  1  single system clock, rising edge
  reset_n  input  1  asynchronous active-low reset
  up_btn  input  1  async, active-high, step day-of-year forward
  down_btn  input  1  async, active-high, step day-of-year back
  load  input  1  synchronous, active-high, load load_val
  load_val  input  7  day-of-year to load
  leap_year  input  1  synchronous, 1 = leap year
  date  output  7  day-of-year, range 1..max_day, fed to dateconverter
  leap_out  output  1  registered copy of leap_year, fed to dateconverter
  date_valid  output  1  one-cycle pulse after any change of date
  wrap  output  1  one-cycle pulse when date wraps in either direction

Function
REQ-005: max_day SHALL be 91 when leap_out=1 and 90 otherwise (Jan-Mar).
REQ-006: up_btn and down_btn SHALL each pass through a SYNC_STAGES-deep synchronizer before any use.
REQ-007: The FSM SHALL have states IDLE, PRESS and REPEAT, plus a registered direction bit.
REQ-008: IDLE->PRESS SHALL occur when exactly one synchronized button is high; date steps once on that same edge.
REQ-009: PRESS->REPEAT SHALL occur after the button stays high for HOLD_CYCLES consecutive cycles; no step occurs on that edge.
REQ-010: In REPEAT, date SHALL step once every REPEAT_CYCLES cycles while the button stays high.
REQ-011: From PRESS or REPEAT, the FSM SHALL return to IDLE on the cycle the active button goes low, or when both buttons are high.
REQ-012: Both synchronized buttons high in IDLE SHALL cause no step and no state change.
REQ-013: Up step SHALL give date+1, or 1 at max_day; down step SHALL give date-1, or max_day at 1; a wrap SHALL pulse wrap for one cycle together with date_valid.
REQ-014: load SHALL have priority over any step and SHALL return the FSM to IDLE with counters cleared.
REQ-015: On load, load_val=0 SHALL load 1, load_val>max_day SHALL load max_day, and other values SHALL load unchanged.
REQ-016: On load, wrap SHALL stay 0.
REQ-017: leap_out SHALL register leap_year each cycle.
REQ-018: If leap_out goes 1->0 while date=91, date SHALL become 90 on the next edge and date_valid SHALL pulse.
REQ-019: date_valid SHALL pulse for exactly one cycle, on the cycle after each edge where date changed value; a load of an equal value SHALL NOT pulse.
REQ-020: Latency SHALL be SYNC_STAGES+1 rising edges from the first edge sampling a button high to the date update.
REQ-021: The hold and repeat counters SHALL be wide enough for their parameters and SHALL NOT wrap.

Reset
REQ-022: Asserting reset_n low SHALL immediately force date=1, leap_out=0, date_valid=0, wrap=0, FSM=IDLE, synchronizers=0, counters=0.
REQ-023: Reset SHALL take effect mid-repeat or mid-load without any further step.
REQ-024: After reset_n rises, the first step SHALL NOT occur until a synchronized button rising edge is detected.

Verification
REQ-025: Reset, then one up_btn pulse of 10 cycles -> date 1->2 at edge 3, date_valid pulses once, FSM returns to IDLE.
REQ-026: Load 90 with leap_year=0, then up press -> date=1, wrap=1 and date_valid=1 for one cycle; down press -> date=90, wrap pulses.
REQ-027: HOLD_CYCLES=8, REPEAT_CYCLES=4, hold up_btn 30 cycles from date=5 -> steps at press, then every 4 cycles after the hold, final date=10.
REQ-028: leap_year=1, load 91, then drop leap_year -> date=90 two edges later, date_valid pulses.
REQ-029: Load with load_val=0 -> date=1; load_val=127 -> date=90; load while up_btn held -> load value wins and the FSM goes to IDLE.
REQ-030: Assert reset_n mid-REPEAT -> outputs reset asynchronously; with both buttons high after release -> no step.

Source files
------------

// File: rtl/date_sequencer_if.sv
// Button, load and date signals shared between the date sequencer and its driver.
// The master drives buttons/load/leap; the sequencer (slave) drives the date outputs.
interface date_sequencer_if;
    logic       up_btn;
    logic       down_btn;
    logic       load;
    logic [6:0] load_val;
    logic       leap_year;
    logic [6:0] date;
    logic       leap_out;
    logic       date_valid;
    logic       wrap;

    modport master (
        output up_btn, down_btn, load, load_val, leap_year,
        input  date, leap_out, date_valid, wrap
    );

    modport slave (
        input  up_btn, down_btn, load, load_val, leap_year,
        output date, leap_out, date_valid, wrap
    );
endinterface

// File: rtl/date_sequencer.sv
// Day-of-year (Jan-Mar) sequencer: synchronized up/down buttons with press-hold
// auto-repeat, clamped load, leap-year aware wrap and shrink from 91 to 90.
module date_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    date_sequencer_if.slave  bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);

    typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_e;

    state_e                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [RW-1:0]          rep_cnt_q, rep_cnt_d;
    logic [SYNC_STAGES-1:0] up_sync_q, up_sync_d;
    logic [SYNC_STAGES-1:0] dn_sync_q, dn_sync_d;
    logic [6:0]             date_q, date_d;
    logic                   leap_out_q, leap_out_d;
    logic                   date_valid_q, date_valid_d;
    logic                   wrap_q, wrap_d;

    logic       up_s, dn_s, active, both;
    logic       step, step_up;
    logic [6:0] max_day, load_clamped;

    assign up_s = up_sync_q[SYNC_STAGES-1];
    assign dn_s = dn_sync_q[SYNC_STAGES-1];
    assign both = up_s & dn_s;
    assign active = dir_q ? up_s : dn_s;
    assign max_day = leap_out_q ? 7'd91 : 7'd90;

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        up_sync_d  = (up_sync_q << 1) | SYNC_STAGES'(bus.up_btn);
        dn_sync_d  = (dn_sync_q << 1) | SYNC_STAGES'(bus.down_btn);
        state_d    = state_q;
        dir_d      = dir_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        step       = 1'b0;
        step_up    = dir_q;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
                if (up_s ^ dn_s) begin
                    step    = 1'b1;
                    step_up = up_s;
                    dir_d   = up_s;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (!active || both) begin
                    state_d = IDLE;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d   = REPEAT;
                    rep_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!active || both) begin
                    state_d = IDLE;
                end else if (rep_cnt_q == REP_MAX) begin
                    // The stepping cycle already counts toward the next interval.
                    step      = 1'b1;
                    rep_cnt_d = REP_ONE;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.load) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            step       = 1'b0;
        end
    end

    always_comb begin
        if (bus.load_val == 7'd0)         load_clamped = 7'd1;
        else if (bus.load_val > max_day)  load_clamped = max_day;
        else                              load_clamped = bus.load_val;

        date_d = date_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            date_d = load_clamped;
        end else if (date_q > max_day) begin
            date_d = max_day;
        end else if (step) begin
            if (step_up) begin
                wrap_d = (date_q == max_day);
                date_d = wrap_d ? 7'd1 : date_q + 7'd1;
            end else begin
                wrap_d = (date_q == 7'd1);
                date_d = wrap_d ? max_day : date_q - 7'd1;
            end
        end
        date_valid_d = (date_d != date_q);
        leap_out_d   = bus.leap_year;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            hold_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            up_sync_q    <= '0;
            dn_sync_q    <= '0;
            date_q       <= 7'd1;
            leap_out_q   <= 1'b0;
            date_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            hold_cnt_q   <= hold_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            up_sync_q    <= up_sync_d;
            dn_sync_q    <= dn_sync_d;
            date_q       <= date_d;
            leap_out_q   <= leap_out_d;
            date_valid_q <= date_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    assign bus.date       = date_q;
    assign bus.leap_out   = leap_out_q;
    assign bus.date_valid = date_valid_q;
    assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_date_sequencer.sv
// Directed bench for date_sequencer: load vectors from a table, then hand-written
// press, wrap, auto-repeat, leap shrink, load-priority and async-reset sequences.
module tb_date_sequencer;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    date_sequencer_if bus();

    date_sequencer #(
        .SYNC_STAGES  (2),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       leap;
        bit [6:0] val;
        bit [6:0] exp_date;
        bit       exp_valid;
    } load_vec_t;

    load_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_load(input logic [6:0] val);
        bus.load     = 1'b1;
        bus.load_val = val;
        tick();
        bus.load     = 1'b0;
        tick();
    endtask

    // Short press (below the hold time): expect exactly one step, wrap as given.
    task automatic short_press(input bit up, input logic [6:0] exp_date, input int exp_wraps,
                               input string name);
        int n_valid = 0;
        int n_wrap = 0;
        int n_orphan = 0;
        if (up) bus.up_btn = 1'b1; else bus.down_btn = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 3) begin
                bus.up_btn   = 1'b0;
                bus.down_btn = 1'b0;
            end
            if (bus.date_valid) n_valid++;
            if (bus.wrap) n_wrap++;
            if (bus.wrap && !bus.date_valid) n_orphan++;
        end
        check({name, "_date"}, bus.date, exp_date);
        check({name, "_valid_pulses"}, n_valid, 1);
        check({name, "_wrap_pulses"}, n_wrap, exp_wraps);
        check({name, "_wrap_without_valid"}, n_orphan, 0);
    endtask

    initial begin
        int step_edge[8];
        int n_steps;
        int n_valid;

        bus.up_btn    = 1'b0;
        bus.down_btn  = 1'b0;
        bus.load      = 1'b0;
        bus.load_val  = 7'd0;
        bus.leap_year = 1'b0;
        reset_n       = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("reset_date", bus.date, 1);
        check("reset_leap_out", bus.leap_out, 0);
        check("reset_date_valid", bus.date_valid, 0);
        check("reset_wrap", bus.wrap, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_date", bus.date, 1);

        // Load table: leap setting applied one edge ahead, then load and compare.
        vecs[0] = '{0, 7'd0,   7'd1,  0};
        vecs[1] = '{0, 7'd127, 7'd90, 1};
        vecs[2] = '{0, 7'd90,  7'd90, 0};
        vecs[3] = '{0, 7'd45,  7'd45, 1};
        vecs[4] = '{1, 7'd91,  7'd91, 1};
        vecs[5] = '{1, 7'd100, 7'd91, 0};
        vecs[6] = '{0, 7'd91,  7'd90, 1};
        vecs[7] = '{0, 7'd1,   7'd1,  1};
        vecs[8] = '{1, 7'd0,   7'd1,  0};
        vecs[9] = '{0, 7'd90,  7'd90, 1};
        for (int i = 0; i < 10; i++) begin
            bus.leap_year = vecs[i].leap;
            tick();
            bus.load     = 1'b1;
            bus.load_val = vecs[i].val;
            tick();
            check($sformatf("load%0d_date", i), bus.date, vecs[i].exp_date);
            check($sformatf("load%0d_valid", i), bus.date_valid, vecs[i].exp_valid);
            check($sformatf("load%0d_wrap", i), bus.wrap, 0);
            check($sformatf("load%0d_leap_out", i), bus.leap_out, vecs[i].leap);
            bus.load = 1'b0;
        end
        tick();

        // Single 10-cycle up press from reset: step at edge 3 only.
        do_reset();
        bus.up_btn = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 10) bus.up_btn = 1'b0;
            check($sformatf("press_e%0d_date", e), bus.date, (e >= 3) ? 2 : 1);
            check($sformatf("press_e%0d_valid", e), bus.date_valid, (e == 3) ? 1 : 0);
        end

        // Wrap in both directions, non-leap and leap.
        do_load(7'd90);
        short_press(1'b1, 7'd1,  1, "up_wrap90");
        short_press(1'b0, 7'd90, 1, "down_wrap90");
        short_press(1'b0, 7'd89, 0, "down_plain");
        bus.leap_year = 1'b1;
        tick();
        do_load(7'd1);
        short_press(1'b0, 7'd91, 1, "down_wrap91");
        short_press(1'b1, 7'd1,  1, "up_wrap91");
        bus.leap_year = 1'b0;
        tick();

        // Leap year drops while date is 91.
        bus.leap_year = 1'b1;
        tick();
        do_load(7'd91);
        check("leap_load91", bus.date, 91);
        bus.leap_year = 1'b0;
        tick();
        check("leap_drop_e1_date", bus.date, 91);
        tick();
        check("leap_drop_e2_date", bus.date, 90);
        check("leap_drop_e2_valid", bus.date_valid, 1);
        tick();
        check("leap_drop_e3_valid", bus.date_valid, 0);

        // Load while up is held: load wins and no step follows.
        do_load(7'd20);
        bus.up_btn = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        check("held_before_load", bus.date, 21);
        bus.load     = 1'b1;
        bus.load_val = 7'd50;
        bus.up_btn   = 1'b0;
        tick();
        check("held_load_date", bus.date, 50);
        check("held_load_valid", bus.date_valid, 1);
        check("held_load_wrap", bus.wrap, 0);
        tick();
        check("held_load_equal_valid", bus.date_valid, 0);
        tick();
        bus.load = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        check("held_load_final", bus.date, 50);

        // Auto-repeat: hold up 30 cycles from 5.
        do_load(7'd5);
        n_steps = 0;
        bus.up_btn = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 30) bus.up_btn = 1'b0;
            if (bus.date_valid) begin
                if (n_steps < 8) step_edge[n_steps] = e;
                n_steps++;
            end
        end
        check("repeat_final_date", bus.date, 10);
        check("repeat_step_count", n_steps, 5);
        if (n_steps == 5) begin
            check("repeat_first_latency", step_edge[0], 3);
            check("repeat_after_hold", (step_edge[1] - step_edge[0]) > 8, 1);
            for (int k = 2; k < 5; k++)
                check($sformatf("repeat_period%0d", k), step_edge[k] - step_edge[k-1], 4);
        end

        // Async reset in the middle of REPEAT, then both buttons high.
        bus.leap_year = 1'b1;
        tick();
        do_load(7'd10);
        bus.up_btn = 1'b1;
        for (int e = 0; e < 20; e++) tick();
        check("mid_repeat_date_advanced", bus.date > 7'd11, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_date", bus.date, 1);
        check("async_reset_leap_out", bus.leap_out, 0);
        check("async_reset_valid", bus.date_valid, 0);
        check("async_reset_wrap", bus.wrap, 0);
        bus.down_btn = 1'b1;
        for (int e = 0; e < 3; e++) tick();
        check("in_reset_date", bus.date, 1);
        reset_n = 1'b1;
        n_valid = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (bus.date_valid) n_valid++;
        end
        check("both_btn_date", bus.date, 1);
        check("both_btn_valid_pulses", n_valid, 0);
        bus.up_btn    = 1'b0;
        bus.down_btn  = 1'b0;
        bus.leap_year = 1'b0;
        for (int e = 0; e < 3; e++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
